// File: rtl/iob_timer_ctrl.sv
// iob_timer_ctrl: sequencing controller for a loadable up-counter with prescaler.
// It latches period/prescale/mode on start, then runs ARM -> RUN -> (DONE) and
// emits tick/done/err pulses. All outputs are registered.
// Build option: define IOB_TIMER_CTRL_IRQ_EN to add a sticky interrupt flag
// (irq_o) set by tick/err pulses and cleared by irq_clr_i.
module iob_timer_ctrl #(
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               cke_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic [DATA_W-1:0]  period_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               busy_o,
    output logic [DATA_W-1:0]  count_o,
    output logic               tick_o,
    output logic               done_o,
    output logic               err_o
`ifdef IOB_TIMER_CTRL_IRQ_EN
    ,
    input  logic               irq_clr_i,
    output logic               irq_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_count;
    logic [DATA_W-1:0]  r_period_lat;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [PRESC_W-1:0] r_presc_lat;
    logic               r_mode_lat;
    logic               r_busy;
    logic               r_tick;
    logic               r_done;
    logic               r_err;

    // A start with a zero period is rejected; anything else (re)starts.
    logic w_start_ok;
    logic w_start_bad;
    logic w_step;
    logic w_expire;
    logic w_tick_set;
    logic w_err_set;

    assign w_start_ok  = start_i && (period_i != '0);
    assign w_start_bad = start_i && (period_i == '0);
    assign w_step      = (r_state == S_RUN) && (r_presc_cnt == r_presc_lat);
    assign w_expire    = w_step && (r_count == r_period_lat - DATA_W'(1));
    // Stop beats start beats expiry; a rejected start does not disturb a run.
    assign w_tick_set  = w_expire && !stop_i && !w_start_ok;
    assign w_err_set   = w_start_bad && !stop_i;

    // Main sequencer: state, counter, prescaler, latched config and pulses.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_period_lat <= '0;
            r_presc_cnt  <= '0;
            r_presc_lat  <= '0;
            r_mode_lat   <= 1'b0;
            r_busy       <= 1'b0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                r_state      <= S_IDLE;
                r_count      <= '0;
                r_period_lat <= '0;
                r_presc_cnt  <= '0;
                r_presc_lat  <= '0;
                r_mode_lat   <= 1'b0;
                r_busy       <= 1'b0;
                r_tick       <= 1'b0;
                r_done       <= 1'b0;
                r_err        <= 1'b0;
            end else if (stop_i) begin
                // Count holds; any expiry in this cycle is swallowed.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_tick  <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_start_ok) begin
                r_state      <= S_ARM;
                r_period_lat <= period_i;
                r_presc_lat  <= presc_i;
                r_mode_lat   <= mode_i;
                r_count      <= '0;
                r_presc_cnt  <= '0;
                r_busy       <= 1'b1;
                r_tick       <= 1'b0;
                r_done       <= 1'b0;
                r_err        <= 1'b0;
            end else begin
                r_err  <= w_err_set;
                r_tick <= w_tick_set;
                r_done <= w_tick_set && !r_mode_lat;
                case (r_state)
                    S_ARM: begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                    S_RUN: begin
                        if (w_step) begin
                            r_presc_cnt <= '0;
                            if (w_expire) begin
                                r_count <= '0;
                                if (!r_mode_lat) begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_count <= r_count + DATA_W'(1);
                            end
                        end else begin
                            r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o  = r_busy;
    assign count_o = r_count;
    assign tick_o  = r_tick;
    assign done_o  = r_done;
    assign err_o   = r_err;

`ifdef IOB_TIMER_CTRL_IRQ_EN
    logic r_irq;

    // Sticky interrupt: rises with the tick/err pulse, set wins over clear.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_irq <= 1'b0;
        end else if (cke_i) begin
            if (rst_i)
                r_irq <= 1'b0;
            else if (w_tick_set || w_err_set)
                r_irq <= 1'b1;
            else if (irq_clr_i)
                r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_iob_timer_ctrl.sv
// Self-checking bench for iob_timer_ctrl: directed scenarios plus random
// stimulus, all checked against a cycle-count based reference model.
module tb_iob_timer_ctrl;
    localparam int DW = 32;
    localparam int PW = 8;

    logic          clk_i = 1'b0;
    logic          arst_i, cke_i, rst_i, start_i, stop_i, mode_i;
    logic [DW-1:0] period_i;
    logic [PW-1:0] presc_i;
    logic          busy_o, tick_o, done_o, err_o;
    logic [DW-1:0] count_o;
`ifdef IOB_TIMER_CTRL_IRQ_EN
    logic          irq_clr_i, irq_o;
    logic          e_irq;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: progress measured as enabled RUN cycles since start.
    bit            m_active, m_arm, m_donep, m_mode;
    longint        m_per, m_psc, m_runcyc;
    logic          e_busy, e_tick, e_done, e_err;
    logic [DW-1:0] e_count;

    iob_timer_ctrl #(.DATA_W(DW), .PRESC_W(PW)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
        .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
        .period_i(period_i), .presc_i(presc_i),
        .busy_o(busy_o), .count_o(count_o), .tick_o(tick_o),
        .done_o(done_o), .err_o(err_o)
`ifdef IOB_TIMER_CTRL_IRQ_EN
        , .irq_clr_i(irq_clr_i), .irq_o(irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 0; m_arm = 0; m_donep = 0; m_mode = 0;
        m_per = 0; m_psc = 0; m_runcyc = 0;
        e_busy = 0; e_tick = 0; e_done = 0; e_err = 0; e_count = '0;
`ifdef IOB_TIMER_CTRL_IRQ_EN
        e_irq = 0;
`endif
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_edge();
        if (!cke_i) return;
        if (rst_i) begin
            model_clear();
            return;
        end
        e_tick = 0; e_done = 0; e_err = 0;
        if (stop_i) begin
            m_active = 0; m_arm = 0; m_donep = 0; e_busy = 0;
        end else if (start_i && period_i != 0) begin
            m_per = longint'(period_i); m_psc = longint'(presc_i); m_mode = mode_i;
            m_runcyc = 0; m_active = 1; m_arm = 1; m_donep = 0;
            e_busy = 1; e_count = '0;
        end else begin
            e_err = start_i;
            if (m_donep) begin
                m_donep = 0;
            end else if (m_arm) begin
                m_arm = 0;
            end else if (m_active) begin
                m_runcyc++;
                e_count = DW'((m_runcyc / (m_psc + 1)) % m_per);
                if ((m_runcyc % (m_psc + 1)) == 0 && e_count == 0) begin
                    e_tick = 1;
                    if (!m_mode) begin
                        e_done = 1; m_active = 0; m_donep = 1; e_busy = 0;
                    end
                end
            end
        end
`ifdef IOB_TIMER_CTRL_IRQ_EN
        if (e_tick || e_err) e_irq = 1;
        else if (irq_clr_i) e_irq = 0;
`endif
    endtask

    task automatic check_all(input string tg);
        chk({tg, "_busy"},  busy_o,  e_busy);
        chk({tg, "_count"}, count_o, e_count);
        chk({tg, "_tick"},  tick_o,  e_tick);
        chk({tg, "_done"},  done_o,  e_done);
        chk({tg, "_err"},   err_o,   e_err);
`ifdef IOB_TIMER_CTRL_IRQ_EN
        chk({tg, "_irq"},   irq_o,   e_irq);
`endif
    endtask

    task automatic drive(input logic st, input logic sp, input logic md,
                         input logic [DW-1:0] per, input logic [PW-1:0] ps);
        start_i = st; stop_i = sp; mode_i = md; period_i = per; presc_i = ps;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0);
    endtask

    // One clock: inputs were set at the preceding negedge.
    task automatic cyc(input string tg);
        @(posedge clk_i);
        model_edge();
        #1;
        check_all(tg);
        @(negedge clk_i);
    endtask

    task automatic do_arst(input string tg);
        arst_i = 1'b1;
        #1;
        model_clear();
        check_all(tg);
        #1;
        arst_i = 1'b0;
    endtask

    // Periodic, period 4, prescale 0: ticks at cycles 6, 10, 14.
    task automatic scen1(input string tg);
        drive(1, 0, 1, 4, 0);
        cyc(tg);
        chk({tg, "_busy1"}, busy_o, 1);
        idle();
        for (int c = 2; c <= 14; c++) begin
            cyc(tg);
            if (c == 6 || c == 10 || c == 14) chk({tg, "_tick_at"}, tick_o, 1);
        end
        drive(0, 1, 0, '0, '0);
        cyc(tg);
        idle();
    endtask

    initial begin
        arst_i = 1'b1; cke_i = 1'b1; rst_i = 1'b0;
        idle();
`ifdef IOB_TIMER_CTRL_IRQ_EN
        irq_clr_i = 1'b0;
`endif
        model_clear();
        @(negedge clk_i);
        do_arst("rst");

        scen1("s1");

        // One-shot, period 3, prescale 2: done+tick together at cycle 11.
        drive(1, 0, 0, 3, 2);
        cyc("s2");
        idle();
        for (int c = 2; c <= 12; c++) begin
            cyc("s2");
            if (c == 11) begin
                chk("s2_done_at", done_o, 1);
                chk("s2_tick_at", tick_o, 1);
                chk("s2_busy_at", busy_o, 0);
            end
            if (c == 12) chk("s2_idle_busy", busy_o, 0);
        end

        // Zero period rejected.
        drive(1, 0, 1, 0, 3);
        cyc("s3");
        chk("s3_err", err_o, 1);
        chk("s3_busy", busy_o, 0);
        idle();
        for (int c = 0; c < 3; c++) cyc("s3");
`ifdef IOB_TIMER_CTRL_IRQ_EN
        chk("s3_irq_sticky", irq_o, 1);
        irq_clr_i = 1'b1;
        cyc("s3");
        irq_clr_i = 1'b0;
        chk("s3_irq_clr", irq_o, 0);
`endif

        // Stop coincides with expiry: nothing fires, count holds 1.
        drive(1, 0, 0, 2, 0);
        cyc("s4");
        idle();
        cyc("s4");
        cyc("s4");
        drive(0, 1, 0, '0, '0);
        cyc("s4");
        idle();
        chk("s4_tick", tick_o, 0);
        chk("s4_done", done_o, 0);
        chk("s4_count", count_o, 1);
        cyc("s4");

        // Mid-run restart at count 3, then a 10-cycle clock-enable gap.
        drive(1, 0, 1, 8, 0);
        cyc("s5");
        idle();
        for (int c = 0; c < 4; c++) cyc("s5");
        chk("s5_count3", count_o, 3);
        drive(1, 0, 1, 5, 0);
        cyc("s5");
        idle();
        for (int c = 0; c < 4; c++) cyc("s5");
        cke_i = 1'b0;
        for (int c = 0; c < 10; c++) cyc("s5_cke");
        cke_i = 1'b1;
        for (int c = 0; c < 12; c++) cyc("s5");
        drive(0, 1, 0, '0, '0);
        cyc("s5");
        idle();

        // Async reset mid-run at count 7, then first scenario again.
        drive(1, 0, 1, 20, 0);
        cyc("s6");
        idle();
        for (int c = 0; c < 8; c++) cyc("s6");
        chk("s6_count7", count_o, 7);
        do_arst("s6_arst");
        @(negedge clk_i);
        scen1("s6r");

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            start_i  = ($urandom_range(0, 15) == 0);
            stop_i   = ($urandom_range(0, 31) == 0);
            mode_i   = 1'($urandom_range(0, 1));
            period_i = DW'($urandom_range(0, 6));
            presc_i  = PW'($urandom_range(0, 3));
            cke_i    = ($urandom_range(0, 7) != 0);
            rst_i    = ($urandom_range(0, 99) == 0);
`ifdef IOB_TIMER_CTRL_IRQ_EN
            irq_clr_i = ($urandom_range(0, 3) == 0);
`endif
            cyc("rnd");
        end
        cke_i = 1'b1; rst_i = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
